wb_arbiter2x1: RTL and testbench
================================

// Module: wb_arbiter2x1
// PURPOSE
//  Shares one pipelined Wishbone slave (e.g. the single-port 32-bit SoC RAM)
//  between two Wishbone masters (typically Ibex instruction and data ports).
//  Round-robin grant, held for the owner's whole cycle (CYC high); tracks
//  outstanding strobes so ownership never changes with acks in flight.
// PARAMETERS
//  MAX_OUTSTANDING  4  max strobes accepted but not yet acked/erred (>=1)
// PORTS
//  clk  input   1          clock for all state
//  rst  input   1          synchronous active-high reset
//  m0   wb_if.slave  intf  master port 0 (cyc,stb,adr,we,sel,wdata -> stall,ack,err,rdata)
//  m1   wb_if.slave  intf  master port 1, same signal set as m0
//  s    wb_if.master intf  shared slave port, same signal set, opposite direction
// BEHAVIOUR
//  State: {IDLE, OWN0, OWN1}; last_grant (1b); outstanding count cnt
//   ($clog2(MAX_OUTSTANDING+1) bits).
//  Reset (and any cycle rst=1): state<=IDLE, last_grant<=1 (m0 wins first tie), cnt<=0.
//  Reset mid-cycle drops ownership immediately; later slave acks are discarded.
//  IDLE: s.cyc=0, s.stb=0; m0/m1 stall=1, ack=0, err=0.
//   Next state: only m0.cyc -> OWN0; only m1.cyc -> OWN1;
//   both -> the master != last_grant; neither -> IDLE.
//   Entering OWNx sets last_grant<=x. Arbitration latency: 1 cycle (registered grant).
//  OWNx: s.cyc=mx.cyc; s.stb=mx.stb & ~cap, cap=(cnt==MAX_OUTSTANDING);
//   s.adr/we/sel/wdata=mx's; mx.stall=s.stall|cap; mx.ack=s.ack; mx.err=s.err;
//   mx.rdata=s.rdata (all combinational, zero added latency once owned).
//   Non-owner: stall=1, ack=0, err=0, rdata=0.
//  cnt: +1 on accept (s.stb & ~s.stall), -1 on s.ack|s.err, both same cycle -> unchanged.
//   Never exceeds MAX_OUTSTANDING (cap blocks stb); ack with cnt=0 -> stays 0, still forwarded.
//  Release: OWNx -> IDLE when mx.cyc=0 (Wishbone abort semantics; cnt<=0, acks
//   arriving afterward are discarded). Ack in last owned cycle is forwarded.
//  No back-to-back handoff: IDLE always inserted between owners (1 dead cycle).
//  rdata of non-owners and all outputs in IDLE held 0 (no X propagation).
// TESTING (slave = 1-cycle-ack RAM, stall=0; MAX_OUTSTANDING=4 unless noted)
//  1 rst 2 cycles, no requests -> s.cyc=0, m0/m1 stall=1, ack=0 every cycle.
//  2 m0 alone: cyc/stb write 0x00000010 <= 0xDEADBEEF sel=F -> stall low from cycle 2,
//    ack cycle 3; then read 0x10 -> rdata 0xDEADBEEF; m1 stall=1 throughout.
//  3 m0,m1 raise cyc same cycle after reset -> m0 owns first; m0 drops cyc ->
//    1 IDLE cycle -> m1 owns; both raise again -> m0 (round-robin alternates).
//  4 m1 pipelined 4 reads, stb held 4 cycles, stall=0 -> 4 acks in order, data
//    matches preloaded words 0x0,0x4,0x8,0xC; cnt never >1.
//  5 MAX_OUTSTANDING=1, slave ack delayed 3 cycles -> second stb stalled until ack,
//    s.stb never high while cnt=1.
//  6 rst asserted while m1 owns with cnt=1 -> next cycle IDLE, cnt=0, trailing
//    slave ack not forwarded to m1 or m0.

Source files
------------

// File: rtl/wb_arbiter2x1.sv
// wb_arbiter2x1: round-robin arbiter sharing one pipelined Wishbone slave between two masters
module wb_arbiter2x1 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic [AW-1:0]   m0_adr,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_stall,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic [AW-1:0]   m1_adr,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_stall,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_cyc,
  output logic            s_stb,
  output logic [AW-1:0]   s_adr,
  output logic            s_we,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_stall,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nxt;
  logic last_grant;
  logic [CW-1:0] cnt, cnt_nxt;
  logic own0, own1, cap, acc, rsp;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign cap = cnt == CW'(MAX_OUTSTANDING);
  assign acc = s_stb & ~s_stall;
  assign rsp = s_ack | s_err;
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (m0_cyc && (!m1_cyc || last_grant)) ? OWN0 : m1_cyc ? OWN1 : IDLE;
    else if (own0 ? !m0_cyc : !m1_cyc)
      state_nxt = IDLE;
  end
  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE || state_nxt == IDLE)
      cnt_nxt = '0;
    else if (acc && !rsp)
      cnt_nxt = cnt + CW'(1);
    else if (rsp && !acc && cnt != '0)
      cnt_nxt = cnt - CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && state_nxt != IDLE)
        last_grant <= state_nxt == OWN1;
    end
  end
  assign s_cyc    = own0 ? m0_cyc : own1 ? m1_cyc : 1'b0;
  assign s_stb    = (own0 ? m0_stb : own1 ? m1_stb : 1'b0) & ~cap;
  assign s_adr    = own0 ? m0_adr : own1 ? m1_adr : '0;
  assign s_we     = own0 ? m0_we : own1 ? m1_we : 1'b0;
  assign s_sel    = own0 ? m0_sel : own1 ? m1_sel : '0;
  assign s_wdata  = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign m0_stall = own0 ? (s_stall | cap) : 1'b1;
  assign m0_ack   = own0 & s_ack;
  assign m0_err   = own0 & s_err;
  assign m0_rdata = own0 ? s_rdata : '0;
  assign m1_stall = own1 ? (s_stall | cap) : 1'b1;
  assign m1_ack   = own1 & s_ack;
  assign m1_err   = own1 & s_err;
  assign m1_rdata = own1 ? s_rdata : '0;
endmodule

// File: tb/tb_wb_arbiter2x1.sv
// tb_wb_arbiter2x1: directed self-checking bench for the two-master Wishbone arbiter
module tb_wb_arbiter2x1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_wdata = 0;
  logic [3:0]  m0_sel = 0;
  logic        m0_stall, m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_wdata = 0;
  logic [3:0]  m1_sel = 0;
  logic        m1_stall, m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_rdata;
  logic        man = 0, man_ack = 0;
  logic        ram_ack = 0;
  logic [31:0] ram_rdata = 0;
  logic [31:0] mem [0:15];
  assign s_stall = 1'b0;
  assign s_err   = 1'b0;
  assign s_ack   = man ? man_ack : ram_ack;
  assign s_rdata = ram_rdata;
  always @(posedge clk) begin
    ram_ack <= 1'b0;
    if (s_cyc && s_stb && !s_stall) begin
      ram_ack <= 1'b1;
      ram_rdata <= s_we ? 32'h0 : mem[s_adr[5:2]];
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end
  wb_arbiter2x1 #(.MAX_OUTSTANDING(4)) u_dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_we(m0_we), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_we(m1_we), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_adr(s_adr), .s_we(s_we), .s_sel(s_sel), .s_wdata(s_wdata),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata)
  );
  logic        n0_cyc = 0, n0_stb = 0;
  logic [31:0] n0_adr = 0;
  logic        n0_stall, n0_ack, n0_err;
  logic [31:0] n0_rdata;
  logic        n1_stall, n1_ack, n1_err;
  logic [31:0] n1_rdata;
  logic        t_cyc, t_stb, t_we;
  logic [31:0] t_adr, t_wdata;
  logic [3:0]  t_sel;
  logic        t_ack = 0;
  wb_arbiter2x1 #(.MAX_OUTSTANDING(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_cyc(n0_cyc), .m0_stb(n0_stb), .m0_adr(n0_adr), .m0_we(1'b0), .m0_sel(4'hF), .m0_wdata(32'h0),
    .m0_stall(n0_stall), .m0_ack(n0_ack), .m0_err(n0_err), .m0_rdata(n0_rdata),
    .m1_cyc(1'b0), .m1_stb(1'b0), .m1_adr(32'h0), .m1_we(1'b0), .m1_sel(4'h0), .m1_wdata(32'h0),
    .m1_stall(n1_stall), .m1_ack(n1_ack), .m1_err(n1_err), .m1_rdata(n1_rdata),
    .s_cyc(t_cyc), .s_stb(t_stb), .s_adr(t_adr), .s_we(t_we), .s_sel(t_sel), .s_wdata(t_wdata),
    .s_stall(1'b0), .s_ack(t_ack), .s_err(1'b0), .s_rdata(32'hCAFE0000)
  );
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++; if ({s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack} !== 6'b001100) begin mismatched++; $display("FAIL reset_outputs cyc%0d: got %b want 001100", i, {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}); end
      compared++; if ({m0_rdata, m1_rdata} !== 64'h0) begin mismatched++; $display("FAIL reset_rdata cyc%0d: got %h want 0", i, {m0_rdata, m1_rdata}); end
      next;
    end
    rst = 1'b0;
    @(negedge clk);
    compared++; if ({s_cyc, m0_stall, m1_stall} !== 3'b011) begin mismatched++; $display("FAIL reset_idle: got %b want 011", {s_cyc, m0_stall, m1_stall}); end
    next;
  endtask
  task automatic test_m0_single;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_sel = 4'hF;
    @(negedge clk);
    compared++; if ({m0_stall, m1_stall, s_stb} !== 3'b110) begin mismatched++; $display("FAIL m0_arb_cycle: got %b want 110", {m0_stall, m1_stall, s_stb}); end
    next;
    @(negedge clk);
    compared++; if ({m0_stall, m1_stall, s_cyc, s_stb, s_we, m0_ack} !== 6'b011110) begin mismatched++; $display("FAIL m0_write_issue: got %b want 011110", {m0_stall, m1_stall, s_cyc, s_stb, s_we, m0_ack}); end
    compared++; if ({s_adr, s_wdata, s_sel} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin mismatched++; $display("FAIL m0_write_bus: got %h want 00000010deadbeeff", {s_adr, s_wdata, s_sel}); end
    next;
    m0_we = 0;
    @(negedge clk);
    compared++; if ({m0_ack, m0_stall, m1_stall, m1_ack} !== 4'b1010) begin mismatched++; $display("FAIL m0_write_ack: got %b want 1010", {m0_ack, m0_stall, m1_stall, m1_ack}); end
    next;
    m0_stb = 0;
    @(negedge clk);
    compared++; if ({m0_ack, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin mismatched++; $display("FAIL m0_read_data: got %h want 1deadbeef", {m0_ack, m0_rdata}); end
    compared++; if ({m1_stall, m1_rdata} !== {1'b1, 32'h0}) begin mismatched++; $display("FAIL m0_nonowner: got %h want 100000000", {m1_stall, m1_rdata}); end
    next;
    m0_cyc = 0;
    @(negedge clk);
    compared++; if ({s_cyc, m0_ack} !== 2'b00) begin mismatched++; $display("FAIL m0_release: got %b want 00", {s_cyc, m0_ack}); end
    next;
  endtask
  task automatic test_round_robin;
    rst = 1;
    next;
    rst = 0;
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk);
    compared++; if ({m0_stall, m1_stall, s_cyc} !== 3'b110) begin mismatched++; $display("FAIL rr_tie_wait: got %b want 110", {m0_stall, m1_stall, s_cyc}); end
    next;
    @(negedge clk);
    compared++; if ({m0_stall, m1_stall, s_cyc} !== 3'b011) begin mismatched++; $display("FAIL rr_m0_first: got %b want 011", {m0_stall, m1_stall, s_cyc}); end
    next;
    m0_cyc = 0;
    @(negedge clk);
    compared++; if ({s_cyc, m1_stall} !== 2'b01) begin mismatched++; $display("FAIL rr_m0_drop: got %b want 01", {s_cyc, m1_stall}); end
    next;
    @(negedge clk);
    compared++; if ({s_cyc, m0_stall, m1_stall} !== 3'b011) begin mismatched++; $display("FAIL rr_dead_cycle: got %b want 011", {s_cyc, m0_stall, m1_stall}); end
    next;
    @(negedge clk);
    compared++; if ({s_cyc, m0_stall, m1_stall} !== 3'b110) begin mismatched++; $display("FAIL rr_m1_owns: got %b want 110", {s_cyc, m0_stall, m1_stall}); end
    next;
    m1_cyc = 0;
    next;
    m0_cyc = 1; m1_cyc = 1;
    next;
    @(negedge clk);
    compared++; if ({m0_stall, m1_stall} !== 2'b01) begin mismatched++; $display("FAIL rr_alternate_m0: got %b want 01", {m0_stall, m1_stall}); end
    next;
    m0_cyc = 0; m1_cyc = 0;
    next;
    next;
  endtask
  task automatic test_pipelined;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h0; m1_sel = 4'hF;
    next;
    for (int i = 0; i < 5; i++) begin
      m1_stb = i < 4;
      m1_adr = 32'(i * 4);
      @(negedge clk);
      if (i < 4) begin
        compared++; if ({m1_stall, s_stb, s_adr} !== {2'b01, 32'(i * 4)}) begin mismatched++; $display("FAIL pipe_issue%0d: got %h want %h", i, {m1_stall, s_stb, s_adr}, {2'b01, 32'(i * 4)}); end
      end
      if (i > 0) begin
        compared++; if ({m1_ack, m1_rdata} !== {1'b1, 32'h11111111 * 32'(i)}) begin mismatched++; $display("FAIL pipe_ack%0d: got %h want %h", i, {m1_ack, m1_rdata}, {1'b1, 32'h11111111 * 32'(i)}); end
      end
      compared++; if (u_dut.cnt !== 3'(i > 0)) begin mismatched++; $display("FAIL pipe_cnt%0d: got %0d want %0d", i, u_dut.cnt, i > 0); end
      compared++; if ({m0_stall, m0_ack} !== 2'b10) begin mismatched++; $display("FAIL pipe_m0_blocked%0d: got %b want 10", i, {m0_stall, m0_ack}); end
      next;
    end
    m1_cyc = 0;
    @(negedge clk);
    compared++; if ({m1_ack, s_cyc} !== 2'b00) begin mismatched++; $display("FAIL pipe_end: got %b want 00", {m1_ack, s_cyc}); end
    next;
    next;
  endtask
  task automatic test_cap;
    n0_cyc = 1; n0_stb = 1; n0_adr = 32'h0;
    next;
    @(negedge clk);
    compared++; if ({t_stb, n0_stall} !== 2'b10) begin mismatched++; $display("FAIL cap_first_stb: got %b want 10", {t_stb, n0_stall}); end
    next;
    n0_adr = 32'h4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++; if ({t_stb, n0_stall, u_dut1.cnt} !== 3'b011) begin mismatched++; $display("FAIL cap_blocked%0d: got %b want 011", i, {t_stb, n0_stall, u_dut1.cnt}); end
      next;
    end
    t_ack = 1;
    @(negedge clk);
    compared++; if ({n0_ack, t_stb, n0_stall} !== 3'b101) begin mismatched++; $display("FAIL cap_ack: got %b want 101", {n0_ack, t_stb, n0_stall}); end
    next;
    t_ack = 0;
    @(negedge clk);
    compared++; if ({t_stb, n0_stall, t_adr} !== {2'b10, 32'h4}) begin mismatched++; $display("FAIL cap_second_stb: got %h want %h", {t_stb, n0_stall, t_adr}, {2'b10, 32'h4}); end
    next;
    n0_stb = 0; n0_cyc = 0;
    next;
    @(negedge clk);
    compared++; if ({t_cyc, n0_stall, u_dut1.cnt} !== 3'b010) begin mismatched++; $display("FAIL cap_release: got %b want 010", {t_cyc, n0_stall, u_dut1.cnt}); end
    next;
  endtask
  task automatic test_reset_mid;
    man = 1; man_ack = 0;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h0;
    next;
    @(negedge clk);
    compared++; if ({m1_stall, s_stb} !== 2'b01) begin mismatched++; $display("FAIL rstmid_issue: got %b want 01", {m1_stall, s_stb}); end
    next;
    m1_stb = 0; rst = 1;
    @(negedge clk);
    compared++; if ({m1_stall, u_dut.cnt} !== 4'b0001) begin mismatched++; $display("FAIL rstmid_owned: got %b want 0001", {m1_stall, u_dut.cnt}); end
    next;
    rst = 0; man_ack = 1;
    @(negedge clk);
    compared++; if ({m1_ack, m0_ack, s_cyc, m1_stall, m0_stall} !== 5'b00011) begin mismatched++; $display("FAIL rstmid_trailing_ack: got %b want 00011", {m1_ack, m0_ack, s_cyc, m1_stall, m0_stall}); end
    compared++; if (u_dut.cnt !== 3'd0) begin mismatched++; $display("FAIL rstmid_cnt: got %0d want 0", u_dut.cnt); end
    next;
    man_ack = 0;
    @(negedge clk);
    compared++; if ({m1_ack, m1_stall, u_dut.cnt} !== 5'b00000) begin mismatched++; $display("FAIL rstmid_regrant: got %b want 00000", {m1_ack, m1_stall, u_dut.cnt}); end
    next;
    m1_cyc = 0;
    next;
    man = 0;
    next;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h11111111 * 32'(i + 1);
    next;
    test_reset;
    test_m0_single;
    test_round_robin;
    test_pipelined;
    test_cap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
